// File: rtl/imm_encoder_pkg.sv
// Shared ImmSel encoding (same codes as ImmGen and the decoder) plus a
// sign-extension range helper used by the immediate range checks.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_SHAMT = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_UPC   = 3'd5;
  localparam logic [2:0] IMM_J     = 3'd6;
  localparam logic [2:0] IMM_I2    = 3'd7;

  // True when v[31:lsb] are all equal, i.e. v fits as a signed (lsb+1)-bit value.
  function automatic logic sext_ok(input logic [31:0] v, input logic [4:0] lsb);
    logic [31:0] sh;
    sh = $unsigned($signed(v) >>> lsb);
    return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/imm_encoder_field_pack.sv
// Combinational immediate scatter: for each ImmSel, the inst bits the
// immediate owns (mask), the immediate already placed there (field), and err.
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  immsel,
  input  logic [31:0] imm,
  output logic [31:0] mask,
  output logic [31:0] field,
  output logic        err
);

  // Per-format mask, scattered field and range/alignment check.
  always_comb begin
    mask  = 32'h0000_0000;
    field = 32'h0000_0000;
    err   = 1'b0;
    case (immsel)
      IMM_I, IMM_I2: begin
        mask  = 32'hFFF0_0000;
        field = {imm[11:0], 20'h0_0000};
        err   = !sext_ok(imm, 5'd11);
      end
      IMM_SHAMT: begin
        mask  = 32'h01F0_0000;
        field = {7'h00, imm[4:0], 20'h0_0000};
        err   = |imm[31:5];
      end
      IMM_S: begin
        mask  = 32'hFE00_0F80;
        field = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
        err   = !sext_ok(imm, 5'd11);
      end
      IMM_B: begin
        mask  = 32'hFE00_0F80;
        field = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
        err   = !sext_ok(imm, 5'd12) || imm[0];
      end
      IMM_U, IMM_UPC: begin
        mask  = 32'hFFFF_F000;
        field = {imm[31:12], 12'h000};
        err   = |imm[11:0];
      end
      IMM_J: begin
        mask  = 32'hFFFF_F000;
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
        err   = !sext_ok(imm, 5'd20) || imm[0];
      end
      default: begin
        mask  = 32'h0000_0000;
        field = 32'h0000_0000;
        err   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: S1 packs and range-checks the immediate, S2 merges it
// into the base word and presents it with a streaming byte address.
module imm_encoder #(
  parameter int ADDR_W   = 12,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_base,
  input  logic [2:0]          in_immsel,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic                out_err,
  output logic [ADDR_W-1:0]   out_addr,
  input  logic                addr_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);
  import imm_encoder_pkg::*;

  localparam logic [ADDR_W-1:0]   ADDR_STEP = ADDR_W'(3'd4);
  localparam logic [ERRCNT_W-1:0] CNT_ONE   = ERRCNT_W'(1'b1);
  localparam logic [ERRCNT_W-1:0] CNT_MAX   = {ERRCNT_W{1'b1}};

  logic [31:0]         pack_mask_s, pack_field_s;
  logic                pack_err_s;
  logic                s1_v_r, s1_err_r;
  logic [31:0]         s1_base_r, s1_mask_r, s1_field_r;
  logic                s2_v_r, out_err_r, clr_pend_r;
  logic [31:0]         out_inst_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ERRCNT_W-1:0] err_cnt_r;
  logic                s1_ld_s, s2_ld_s, out_xfer_s;

  imm_field_pack u_pack (
    .immsel (in_immsel),
    .imm    (in_imm),
    .mask   (pack_mask_s),
    .field  (pack_field_s),
    .err    (pack_err_s)
  );

  assign s2_ld_s    = !s2_v_r || out_ready;
  assign s1_ld_s    = !s1_v_r || s2_ld_s;
  assign out_xfer_s = s2_v_r && out_ready;

  assign in_ready  = s1_ld_s;
  assign out_valid = s2_v_r;
  assign out_inst  = out_inst_r;
  assign out_err   = out_err_r;
  assign out_addr  = addr_r;
  assign err_cnt   = err_cnt_r;

  // S1: capture base and the packed immediate when the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r     <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_base_r  <= 32'h0000_0000;
      s1_mask_r  <= 32'h0000_0000;
      s1_field_r <= 32'h0000_0000;
    end else if (s1_ld_s) begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        s1_err_r   <= pack_err_s;
        s1_base_r  <= in_base;
        s1_mask_r  <= pack_mask_s;
        s1_field_r <= pack_field_s;
      end
    end
  end

  // S2: merge field into base; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_r     <= 1'b0;
      out_inst_r <= 32'h0000_0000;
      out_err_r  <= 1'b0;
    end else if (s2_ld_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        out_inst_r <= (s1_base_r & ~s1_mask_r) | s1_field_r;
        out_err_r  <= s1_err_r;
      end
    end
  end

  // Address and error count advance on output transfers. A clear that arrives
  // while a word is stalled on the output is deferred so that word's address
  // stays stable; the following word then starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      clr_pend_r <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      if (out_xfer_s) begin
        addr_r     <= (addr_clr || clr_pend_r) ? '0 : addr_r + ADDR_STEP;
        clr_pend_r <= 1'b0;
      end else if (addr_clr) begin
        if (s2_v_r) begin
          clr_pend_r <= 1'b1;
        end else begin
          addr_r <= '0;
        end
      end
      if (out_xfer_s && out_err_r && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, stall/reset cases,
// and randomized words scored against a behavioural encoding model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, addr_clr;
  logic [31:0] in_base, in_imm, out_inst;
  logic [2:0]  in_immsel;
  logic [11:0] out_addr;
  logic [7:0]  err_cnt;

  int          n_checks, n_fail;
  logic [32:0] exp_q[$];
  int          exp_addr, exp_cnt;
  int          ready_mode;
  logic        clr_req;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(12), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_immsel(in_immsel), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_addr(out_addr), .addr_clr(addr_clr), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding: bit placement by format, range checks by arithmetic.
  function automatic logic [32:0] ref_enc(input logic [31:0] base, input logic [2:0] sel,
                                          input logic [31:0] imm);
    logic [31:0] inst;
    logic        err;
    int          si;
    inst = base;
    si   = $signed(imm);
    err  = 1'b0;
    case (sel)
      3'd0, 3'd7: begin
        inst[31:20] = imm[11:0];
        err = (si < -2048) || (si > 2047);
      end
      3'd1: begin
        inst[24:20] = imm[4:0];
        err = imm > 32'd31;
      end
      3'd2: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        err = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        inst[31] = imm[12]; inst[30:25] = imm[10:5];
        inst[11:8] = imm[4:1]; inst[7] = imm[11];
        err = (si < -4096) || (si > 4095) || (si % 2 != 0);
      end
      3'd4, 3'd5: begin
        inst[31:12] = imm[31:12];
        err = (imm % 32'd4096) != 32'd0;
      end
      default: begin
        inst[31] = imm[20]; inst[30:21] = imm[10:1];
        inst[20] = imm[11]; inst[19:12] = imm[19:12];
        err = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
      end
    endcase
    return {err, inst};
  endfunction

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_addr = 0;
        exp_cnt  = 0;
      end else begin
        if (out_valid && out_ready) begin
          check("mon_errcnt", err_cnt, exp_cnt);
          if (exp_q.size() == 0) begin
            check("mon_unexpected_word", {31'b0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("mon_inst", out_inst, e[31:0]);
            check("mon_err", {31'b0, out_err}, {31'b0, e[32]});
            check("mon_addr", {20'b0, out_addr}, exp_addr);
            if (e[32] && exp_cnt < 255) exp_cnt++;
          end
          exp_addr = addr_clr ? 0 : (exp_addr + 4) % 4096;
        end else if (addr_clr && !out_valid) begin
          exp_addr = 0;
        end
        if (in_valid && in_ready) exp_q.push_back(ref_enc(in_base, in_immsel, in_imm));
      end
    end
  endtask

  // Drives out_ready/addr_clr 2 units after each rising edge.
  task automatic ready_gen();
    out_ready = 1'b1;
    addr_clr  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom % 4) != 0;
      endcase
      addr_clr = clr_req || (ready_mode == 2 && ($urandom % 20) == 0 && (!out_valid || out_ready));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] b, input logic [2:0] s, input logic [31:0] i);
    logic ir;
    bit   done;
    done = 0;
    in_valid = 1'b1; in_base = b; in_immsel = s; in_imm = i;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      ir = in_ready;
      step();
      done = ir;
    end
    if (!done) check("send_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst, input logic err,
                            input logic [11:0] addr);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_err"}, {31'b0, out_err}, {31'b0, err});
    check({tag, "_addr"}, {20'b0, out_addr}, {20'b0, addr});
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    step();
  endtask

  task automatic rand_word(output logic [31:0] b, output logic [2:0] s, output logic [31:0] i);
    b = $urandom;
    s = 3'($urandom_range(0, 7));
    case ($urandom % 4)
      0:       i = $urandom;
      1:       i = $urandom_range(0, 63);
      2:       i = -$urandom_range(0, 5000);
      default: i = $urandom & 32'hFFFF_F000;
    endcase
  endtask

  initial begin
    logic [31:0] b, i;
    logic [2:0]  s;
    n_checks = 0; n_fail = 0; exp_addr = 0; exp_cnt = 0;
    ready_mode = 0; clr_req = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_base = 32'h0; in_immsel = 3'd0; in_imm = 32'h0;
    fork
      monitor();
      ready_gen();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_out_addr", {20'b0, out_addr}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    send(32'h0000_8093, 3'd0, 32'hFFFF_FFFF); expect_out("t1_i", 32'hFFF0_8093, 1'b0, 12'd0);
    send(32'h0000_006F, 3'd6, 32'h0000_0008); expect_out("t3_j", 32'h0080_006F, 1'b0, 12'd4);
    send(32'h0000_9093, 3'd1, 32'h0000_0003); expect_out("t3_shamt", 32'h0030_9093, 1'b0, 12'd8);
    send(32'h0000_00B7, 3'd4, 32'h1234_5001); expect_out("t4_u", 32'h1234_50B7, 1'b1, 12'd12);
    @(negedge clk);
    check("t4_err_cnt", {24'b0, err_cnt}, 32'd1);
    step();
    send(32'h0000_0063, 3'd3, 32'hFFFF_FFFC); expect_out("t2_b", 32'hFE00_0EE3, 1'b0, 12'd16);
    send(32'h0000_0063, 3'd3, 32'h0000_0003); expect_out("t2_b_err", 32'h0000_0163, 1'b1, 12'd20);
    send(32'h0000_0013, 3'd0, 32'h0000_0800); expect_out("i_2048", 32'h8000_0013, 1'b1, 12'd24);
    send(32'h0000_9093, 3'd1, 32'h0000_0020); expect_out("shamt_32", 32'h0000_9093, 1'b1, 12'd28);

    ready_mode = 2;
    for (int w = 0; w < 300; w++) begin
      rand_word(b, s, i);
      send(b, s, i);
      if ($urandom % 4 == 0) step();
    end
    drain();
    ready_mode = 0;
    step();
    for (int w = 0; w < 1100; w++) begin
      rand_word(b, s, i);
      send(b, s, i);
    end
    drain();
    check("err_cnt_saturated", {24'b0, err_cnt}, 32'h0000_00FF);

    clr_req = 1'b1; step(); clr_req = 1'b0;
    ready_mode = 1; step();
    send(32'h0000_0013, 3'd0, 32'h0000_0005);
    send(32'h0000_2023, 3'd2, 32'h0000_0008);
    in_valid = 1'b1; in_base = 32'h0000_0037; in_immsel = 3'd4; in_imm = 32'hABCD_E000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("t5_hold_inst", out_inst, 32'h0050_0013);
      check("t5_hold_addr", {20'b0, out_addr}, 32'd0);
    end
    step();
    ready_mode = 0;
    send(32'h0000_0037, 3'd4, 32'hABCD_E000);
    @(negedge clk);
    check("t5_w2_inst", out_inst, 32'h0000_2423);
    check("t5_w2_addr", {20'b0, out_addr}, 32'd4);
    @(posedge clk);
    @(negedge clk);
    check("t5_w3_inst", out_inst, 32'hABCD_E037);
    check("t5_w3_addr", {20'b0, out_addr}, 32'd8);
    step();
    drain();

    ready_mode = 1; step();
    send(32'h0000_0013, 3'd0, 32'hFFFF_F000);
    send(32'h0000_0013, 3'd0, 32'h0000_0001);
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_out_addr", {20'b0, out_addr}, 32'd0);
    check("t6_err_cnt", {24'b0, err_cnt}, 32'd0);
    step();
    rst_n = 1'b1; ready_mode = 0;
    step();
    send(32'h0000_0017, 3'd5, 32'h0000_1000);
    expect_out("t6_after", 32'h0000_1017, 1'b0, 12'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
